decoder_cpu_ocimem_sequencer: RTL and testbench
===============================================

# decoder_cpu_ocimem_sequencer

Sysclk-domain sequencer for the CPU debug module's on-chip memory (OCI RAM) path. It turns the decoded JTAG action strobes and the `jdo` shift-register contents into address-load, read and write transactions on a word-wide, waitrequest-handshaked memory port. It returns results to the debug transport through `MonDReg`, `monitor_ready` and `monitor_error`. It sits between the debug-module wrapper's sysclk action outputs and the debug RAM/ROM.

## Interface
- `ADDR_W`, 8: word-address width of the memory port (1..30).
- `TIMEOUT`, 255: maximum number of waitrequest-stalled cycles before an access aborts (≥2).

- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `take_action_ocimem_a` in 1: one-cycle strobe for address load, with an optional read.
- `take_no_action_ocimem_a` in 1: one-cycle strobe for read-next.
- `take_action_ocimem_b` in 1: one-cycle strobe for write-next.
- `jdo` in 38: command payload, sampled only in the strobe cycle.
- `mem_readdata` in 32: read data; valid in the cycle where `mem_read` is high and `mem_waitrequest` is low.
- `mem_waitrequest` in 1: slave stall.
- `mem_address` out ADDR_W: current word address (the internal pointer).
- `mem_read` out 1: read request.
- `mem_write` out 1: write request.
- `mem_writedata` out 32: write data.
- `MonDReg` out 32: last successfully read word.
- `monitor_ready` out 1: the last command has completed; the result is valid.
- `monitor_error` out 1: sticky error flag.
- `busy` out 1: a memory access is in flight.

## Operation
- States: IDLE, RD, WR.
- Reset values: state IDLE, `mem_address` 0, `mem_read` 0, `mem_write` 0, `mem_writedata` 0, `MonDReg` 0, `monitor_ready` 0, `monitor_error` 0, `busy` 0, timeout counter 0.
- Commands are accepted only in IDLE.
- If several strobes are high in the same cycle, priority is `take_action_ocimem_a` > `take_action_ocimem_b` > `take_no_action_ocimem_a`. Lower-priority strobes are ignored silently.
- `take_action_ocimem_a` (address load):
  - Pointer ← `jdo[ADDR_W-1:0]`.
  - `monitor_error` is cleared.
  - If `jdo[35]`=1, go to RD using the newly loaded address.
  - Otherwise stay in IDLE and set `monitor_ready`=1 on the next edge.
- `take_no_action_ocimem_a` (read-next): go to RD at the current pointer.
- `take_action_ocimem_b` (write-next): `mem_writedata` ← `jdo[31:0]`, then go to WR at the current pointer.
- Entering RD or WR clears `monitor_ready`, sets `busy`, zeroes the timeout counter, and asserts `mem_read` or `mem_write` respectively.
- RD completion, in a cycle with `mem_waitrequest`=0:
  - `MonDReg` ← `mem_readdata`.
  - Pointer ← pointer+1.
  - `monitor_ready` ← 1; `mem_read` ← 0; `busy` ← 0; state → IDLE.
- WR completion: the same as RD completion, except `MonDReg` is unchanged.
- Pointer increment wraps modulo 2^ADDR_W (all-ones → 0).
- Timeout:
  - Each cycle in RD/WR with `mem_waitrequest`=1 increments the counter.
  - If waitrequest is still high when the counter equals TIMEOUT-1, the next edge aborts the access: request deasserted, state → IDLE, `busy` 0, `monitor_error` 1, `monitor_ready` 1.
  - On abort, the pointer and `MonDReg` are unchanged.
- Overrun: a strobe arriving while `busy`=1 is dropped and sets `monitor_error`=1. The in-flight access continues unaffected.
- `monitor_error` clears only on reset or on an accepted `take_action_ocimem_a`.
- Reset asserted mid-access: all outputs go to their reset values immediately (asynchronously). The access is abandoned with no completion.

## Timing
- A strobe sampled at edge N asserts `mem_read`/`mem_write`, `busy`=1 and `monitor_ready`=0 after edge N.
- A zero-wait access completes at edge N+1. `MonDReg`, the pointer increment and `monitor_ready`=1 are visible after edge N+1, giving 2-cycle strobe-to-ready latency.
- Each waitrequest cycle adds exactly one cycle of latency.
- Address load without read: `monitor_ready`=1 and the new `mem_address` are visible after edge N.
- `mem_address` and `mem_writedata` are stable for the whole time the request is asserted.
- Requests deassert in the cycle following completion.
- No back-to-back acceptance: the earliest next accepted strobe is at the edge after completion, i.e. the cycle in which `busy`=0.

## Test plan
- Address load without read:
  - Stimulus: `take_action_ocimem_a` with `jdo[35]`=0, `jdo[7:0]`=8'h40.
  - Response: `mem_address`=8'h40 and `monitor_ready`=1 one cycle later; `mem_read` never asserted.
- Load-and-read plus read-next:
  - Stimulus: load with `jdo[35]`=1, address 8'h10; memory returns 32'hDEADBEEF with zero wait; then `take_no_action_ocimem_a`.
  - Response: `MonDReg`=32'hDEADBEEF 2 cycles after the strobe with `mem_address`=8'h11; the second read hits address 0x11.
- Write with stall:
  - Stimulus: `take_action_ocimem_b` with `jdo[31:0]`=32'h12345678; waitrequest high for 3 cycles.
  - Response: `mem_write` is high for 4 cycles with stable data; `monitor_ready` rises at strobe+5; `MonDReg` unchanged.
- Wrap and priority:
  - Stimulus: pointer at 8'hFF; `take_action_ocimem_b` and `take_no_action_ocimem_a` strobed in the same cycle.
  - Response: only the write is performed, at 0xFF; the pointer becomes 0x00; `monitor_error` stays 0.
- Timeout with TIMEOUT=4:
  - Stimulus: waitrequest held high.
  - Response: the read aborts after 4 stall cycles; `monitor_error`=1 and `monitor_ready`=1; pointer unchanged.
  - Follow-up: an address-load strobe clears `monitor_error`.
- Overrun and reset:
  - Stimulus: a strobe arrives mid-stall.
  - Response: `monitor_error`=1 and the access still completes.
  - Stimulus: `reset` asserted mid-access.
  - Response: `mem_read`, `busy`, `mem_address` and `MonDReg` are 0 without waiting for a clock edge.

Source files
------------

// File: rtl/decoder_cpu_ocimem_sequencer.sv
// OCI RAM sequencer: turns debug JTAG action strobes into address-load,
// read and write transactions on a waitrequest-handshaked memory port.
module decoder_cpu_ocimem_sequencer #(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              take_action_ocimem_a,
   input  logic              take_no_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic [37:0]       jdo,
   input  logic [31:0]       mem_readdata,
   input  logic              mem_waitrequest,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_read,
   output logic              mem_write,
   output logic [31:0]       mem_writedata,
   output logic [31:0]       MonDReg,
   output logic              monitor_ready,
   output logic              monitor_error,
   output logic              busy
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE,
      RD,
      WR
   } state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] ptr_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic              rd_nx, wr_nx, busy_nx, ready_nx, err_nx;
   logic [31:0]       wdata_nx, mon_nx;
   logic              any_strobe;

   // Only bit 35 of the upper command field has meaning here.
   logic unused_jdo;
   assign unused_jdo = ^{jdo[37:36], jdo[34:32]};

   assign any_strobe = take_action_ocimem_a | take_action_ocimem_b |
                       take_no_action_ocimem_a;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         mem_address   <= '0;
         mem_read      <= 1'b0;
         mem_write     <= 1'b0;
         mem_writedata <= '0;
         MonDReg       <= '0;
         monitor_ready <= 1'b0;
         monitor_error <= 1'b0;
         busy          <= 1'b0;
         cnt           <= '0;
      end else begin
         state         <= state_nx;
         mem_address   <= ptr_nx;
         mem_read      <= rd_nx;
         mem_write     <= wr_nx;
         mem_writedata <= wdata_nx;
         MonDReg       <= mon_nx;
         monitor_ready <= ready_nx;
         monitor_error <= err_nx;
         busy          <= busy_nx;
         cnt           <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      ptr_nx   = mem_address;
      rd_nx    = mem_read;
      wr_nx    = mem_write;
      wdata_nx = mem_writedata;
      mon_nx   = MonDReg;
      ready_nx = monitor_ready;
      err_nx   = monitor_error;
      busy_nx  = busy;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            if (take_action_ocimem_a) begin
               ptr_nx = jdo[ADDR_W-1:0];
               err_nx = 1'b0;
               if (jdo[35]) begin
                  state_nx = RD;
                  rd_nx    = 1'b1;
                  busy_nx  = 1'b1;
                  ready_nx = 1'b0;
                  cnt_nx   = '0;
               end else begin
                  ready_nx = 1'b1;
               end
            end else if (take_action_ocimem_b) begin
               wdata_nx = jdo[31:0];
               state_nx = WR;
               wr_nx    = 1'b1;
               busy_nx  = 1'b1;
               ready_nx = 1'b0;
               cnt_nx   = '0;
            end else if (take_no_action_ocimem_a) begin
               state_nx = RD;
               rd_nx    = 1'b1;
               busy_nx  = 1'b1;
               ready_nx = 1'b0;
               cnt_nx   = '0;
            end
         end
         RD, WR: begin
            // A strobe during an access is an overrun; the access goes on.
            if (any_strobe)
               err_nx = 1'b1;
            if (!mem_waitrequest) begin
               if (state == RD)
                  mon_nx = mem_readdata;
               ptr_nx   = mem_address + ADDR_W'(1);
               ready_nx = 1'b1;
               rd_nx    = 1'b0;
               wr_nx    = 1'b0;
               busy_nx  = 1'b0;
               state_nx = IDLE;
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
               ready_nx = 1'b1;
               err_nx   = 1'b1;
               rd_nx    = 1'b0;
               wr_nx    = 1'b0;
               busy_nx  = 1'b0;
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_decoder_cpu_ocimem_sequencer.sv
// Scoreboard bench for decoder_cpu_ocimem_sequencer (ADDR_W=8, TIMEOUT=4).
module tb_decoder_cpu_ocimem_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sa = 1'b0, sn = 1'b0, sb = 1'b0;
   logic [37:0] jdo = '0;
   logic [31:0] mem_readdata;
   logic        mem_waitrequest;
   logic [7:0]  mem_address;
   logic        mem_read, mem_write;
   logic [31:0] mem_writedata, MonDReg;
   logic        monitor_ready, monitor_error, busy;

   int vectors = 0;
   int errors = 0;
   int cyc = 0;
   int stall_set = 0;
   int stall_used = 0;

   typedef struct {
      logic       wr;
      logic [7:0] addr;
      logic [31:0] wd;
      logic       abort;
      int         cycles;
   } bus_t;

   typedef struct {
      int          lat;
      logic [31:0] mon;
      logic [7:0]  addr;
      logic        err;
      int          cyc;
   } st_t;

   bus_t bus_q[$];
   st_t  st_q[$];

   decoder_cpu_ocimem_sequencer #(.ADDR_W(8), .TIMEOUT(4)) dut (
      .clk(clk),
      .reset(reset),
      .take_action_ocimem_a(sa),
      .take_no_action_ocimem_a(sn),
      .take_action_ocimem_b(sb),
      .jdo(jdo),
      .mem_readdata(mem_readdata),
      .mem_waitrequest(mem_waitrequest),
      .mem_address(mem_address),
      .mem_read(mem_read),
      .mem_write(mem_write),
      .mem_writedata(mem_writedata),
      .MonDReg(MonDReg),
      .monitor_ready(monitor_ready),
      .monitor_error(monitor_error),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Slave model: fixed data pattern, programmable stall length.
   assign mem_readdata = (mem_address == 8'h10) ? 32'hDEADBEEF
                                               : {24'hC00000, mem_address};
   assign mem_waitrequest = (stall_used < stall_set);

   always @(posedge clk) begin
      if (mem_read | mem_write) stall_used <= stall_used + 1;
      else stall_used <= 0;
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic issue(input logic a, input logic n, input logic b,
                        input logic [37:0] d);
      @(posedge clk); #1;
      sa = a; sn = n; sb = b; jdo = d;
      @(posedge clk); #1;
      sa = 0; sn = 0; sb = 0;
   endtask

   task automatic push_bus(input logic wr, input logic [7:0] addr,
                           input logic [31:0] wd, input logic abort,
                           input int cycles);
      bus_t e;
      e.wr = wr; e.addr = addr; e.wd = wd; e.abort = abort; e.cycles = cycles;
      bus_q.push_back(e);
   endtask

   task automatic push_st(input int lat, input logic [31:0] mon,
                          input logic [7:0] addr, input logic err);
      st_t e;
      e.lat = lat; e.mon = mon; e.addr = addr; e.err = err; e.cyc = cyc;
      st_q.push_back(e);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((bus_q.size() != 0 || st_q.size() != 0) && n < 60) begin
         @(posedge clk);
         n++;
      end
      if (bus_q.size() != 0 || st_q.size() != 0) begin
         vectors++;
         errors++;
         $display("FAIL drain: queues bus=%0d st=%0d not empty",
                  bus_q.size(), st_q.size());
         bus_q.delete();
         st_q.delete();
      end
      #1;
   endtask

   // Bus monitor: request address/data stability, beats and aborts.
   logic req_prev = 1'b0;
   logic done = 1'b0;
   int   ncyc = 0;

   always @(negedge clk) begin
      logic req;
      bus_t e;
      req = mem_read | mem_write;
      if (req) begin
         if (bus_q.size() == 0) begin
            chk("bus_unexpected", {31'b0, req}, 32'd0);
         end else if (!done) begin
            e = bus_q[0];
            ncyc++;
            chk("bus_addr", {24'b0, mem_address}, {24'b0, e.addr});
            if (e.wr) chk("bus_wdata", mem_writedata, e.wd);
            if (!mem_waitrequest) begin
               void'(bus_q.pop_front());
               chk("bus_kind", {31'b0, mem_write}, {31'b0, e.wr});
               chk("bus_abort", 32'd0, {31'b0, e.abort});
               chk("bus_cycles", ncyc, e.cycles);
               done = 1'b1;
               ncyc = 0;
            end
         end
      end else if (req_prev && !done) begin
         if (bus_q.size() != 0) begin
            e = bus_q.pop_front();
            chk("bus_aborted", 32'd1, {31'b0, e.abort});
            if (e.cycles >= 0) chk("abort_cycles", ncyc, e.cycles);
         end
         ncyc = 0;
      end
      if (!req) done = 1'b0;
      req_prev = req;
   end

   // Status monitor: result registers when a command reports ready.
   always @(negedge clk) begin
      st_t e;
      if (!reset && st_q.size() != 0) begin
         e = st_q[0];
         if (monitor_ready && !busy) begin
            void'(st_q.pop_front());
            chk("latency", cyc - e.cyc, e.lat);
            chk("MonDReg", MonDReg, e.mon);
            chk("address", {24'b0, mem_address}, {24'b0, e.addr});
            chk("error", {31'b0, monitor_error}, {31'b0, e.err});
            chk("req_idle", {30'b0, mem_read, mem_write}, 32'd0);
         end else if (cyc - e.cyc > 40) begin
            void'(st_q.pop_front());
            chk("ready_timeout", {31'b0, monitor_ready}, 32'd1);
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_address", {24'b0, mem_address}, 32'd0);
      chk("rst_read", {31'b0, mem_read}, 32'd0);
      chk("rst_write", {31'b0, mem_write}, 32'd0);
      chk("rst_wdata", mem_writedata, 32'd0);
      chk("rst_mon", MonDReg, 32'd0);
      chk("rst_ready", {31'b0, monitor_ready}, 32'd0);
      chk("rst_error", {31'b0, monitor_error}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      reset = 0;

      // Address load without read.
      issue(1, 0, 0, {2'b0, 1'b0, 35'h40});
      push_st(0, 32'h0, 8'h40, 0);
      wait_done();

      // Load-and-read, then read-next.
      issue(1, 0, 0, {2'b0, 1'b1, 35'h10});
      push_bus(0, 8'h10, 32'h0, 0, 1);
      push_st(1, 32'hDEADBEEF, 8'h11, 0);
      wait_done();
      issue(0, 1, 0, 38'h0);
      push_bus(0, 8'h11, 32'h0, 0, 1);
      push_st(1, 32'hC0000011, 8'h12, 0);
      wait_done();

      // Write with three stall cycles.
      stall_set = 3;
      issue(0, 0, 1, {6'b0, 32'h12345678});
      push_bus(1, 8'h12, 32'h12345678, 0, 4);
      push_st(4, 32'hC0000011, 8'h13, 0);
      wait_done();
      stall_set = 0;

      // Pointer at FF, write and read-next together: write wins, wraps.
      issue(1, 0, 0, {6'b0, 32'hFF});
      push_st(0, 32'hC0000011, 8'hFF, 0);
      wait_done();
      issue(0, 1, 1, {6'b0, 32'hCAFEF00D});
      push_bus(1, 8'hFF, 32'hCAFEF00D, 0, 1);
      push_st(1, 32'hC0000011, 8'h00, 0);
      wait_done();

      // Timeout: read-next with waitrequest held high.
      stall_set = 100;
      issue(0, 1, 0, 38'h0);
      push_bus(0, 8'h00, 32'h0, 1, 4);
      push_st(4, 32'hC0000011, 8'h00, 1);
      wait_done();
      stall_set = 0;
      issue(1, 0, 0, {6'b0, 32'h20});
      push_st(0, 32'hC0000011, 8'h20, 0);
      wait_done();

      // Overrun strobe mid-stall.
      stall_set = 3;
      issue(1, 0, 0, {2'b0, 1'b1, 35'h20});
      push_bus(0, 8'h20, 32'h0, 0, 4);
      push_st(4, 32'hC0000020, 8'h21, 1);
      @(posedge clk); #1;
      sn = 1;
      @(posedge clk); #1;
      sn = 0;
      wait_done();

      // Reset in the middle of a stalled read.
      stall_set = 100;
      issue(0, 1, 0, 38'h0);
      push_bus(0, 8'h21, 32'h0, 1, -1);
      @(posedge clk); #1;
      chk("pre_rst_read", {31'b0, mem_read}, 32'd1);
      reset = 1;
      #1;
      chk("arst_read", {31'b0, mem_read}, 32'd0);
      chk("arst_busy", {31'b0, busy}, 32'd0);
      chk("arst_address", {24'b0, mem_address}, 32'd0);
      chk("arst_mon", MonDReg, 32'd0);
      chk("arst_error", {31'b0, monitor_error}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 0;
      stall_set = 0;
      wait_done();

      // Recovery after reset.
      issue(1, 0, 0, {2'b0, 1'b1, 35'h10});
      push_bus(0, 8'h10, 32'h0, 0, 1);
      push_st(1, 32'hDEADBEEF, 8'h11, 0);
      wait_done();

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
